// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file: oversampled SCL/SDA, auto-incrementing pointer,
// repeated START, write strobe and a registered local read port.
module i2c_glitch_filter #(
  parameter int FILTER = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Output follows the synchronised level only after FILTER consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] != dout) begin
        if (cnt == CW'(FILTER - 1)) begin
          dout <= sync[1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module i2c_target_regfile #(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter int         PTR_W    = 4,
  parameter int         FILTER   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] loc_addr,
  output logic [7:0]       loc_rdata
);
  localparam int DEPTH = 1 << PTR_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_WDATA, ST_RDATA, ST_IGNORE
  } state_t;

  state_t                     state;
  logic [DEPTH-1:0][7:0]      mem;
  logic [PTR_W-1:0]           ptr;
  logic [6:0]                 sr;
  logic [3:0]                 bit_cnt;
  logic                       rw;
  logic [1:0]                 pad;
  logic [1:0]                 flt;
  logic                       scl_q, sda_q;
  logic                       scl_f, sda_f;
  logic                       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0]                 rx_byte;

  assign pad = {scl_i, sda_i};

  for (genvar g = 0; g < 2; g++) begin : g_flt
    i2c_glitch_filter #(.FILTER(FILTER)) u_flt (
      .clk  (clk),
      .reset(reset),
      .din  (pad[g]),
      .dout (flt[g])
    );
  end

  assign scl_f    = flt[1];
  assign sda_f    = flt[0];
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte  = {sr, sda_f};

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // bit_cnt counts SCL rises within a byte; 8 = ACK slot pending, 9 = ACK slot high phase done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem       <= '0;
      ptr       <= '0;
      sr        <= '0;
      bit_cnt   <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      loc_rdata <= '0;
    end else begin
      wr_stb    <= 1'b0;
      loc_rdata <= mem[loc_addr];
      if (start_c) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else if (stop_c) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA, ST_ADDR_ACK: begin
            if (scl_rise && bit_cnt < 4'd8 && state != ST_ADDR_ACK) begin
              sr      <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                case (state)
                  ST_ADDR: begin
                    if (rx_byte[7:1] == I2C_ADDR) begin
                      state <= ST_ADDR_ACK;
                      rw    <= rx_byte[0];
                      busy  <= 1'b1;
                    end else begin
                      state <= ST_IGNORE;
                      busy  <= 1'b0;
                    end
                  end
                  ST_PTR: ptr <= rx_byte[PTR_W-1:0];
                  default: begin
                    mem[ptr] <= rx_byte;
                    wr_stb   <= 1'b1;
                    wr_addr  <= ptr;
                    wr_data  <= rx_byte;
                    ptr      <= ptr + 1'b1;
                  end
                endcase
              end
            end else if (scl_rise && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              sda_oe  <= 1'b0;
              case (state)
                ST_ADDR_ACK: begin
                  if (rw) begin
                    // First read bit goes out on the same fall that ends the ACK slot.
                    state  <= ST_RDATA;
                    sr     <= mem[ptr][6:0];
                    sda_oe <= ~mem[ptr][7];
                  end else begin
                    state <= ST_PTR;
                  end
                end
                ST_PTR:  state <= ST_WDATA;
                default: state <= state;
              endcase
            end
          end
          ST_RDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_rise && bit_cnt == 4'd8) begin
              ptr <= ptr + 1'b1;
              if (!sda_f) bit_cnt <= 4'd9;
              else        state   <= ST_IGNORE;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
            end else if (scl_fall && bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              sr      <= mem[ptr][6:0];
              sda_oe  <= ~mem[ptr][7];
            end else if (scl_fall && bit_cnt != 4'd0) begin
              sda_oe <= ~sr[6];
              sr     <= {sr[5:0], 1'b1};
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: bit-banged I2C controller driving i2c_target_regfile, expected values hand-computed.
module tb_i2c_target_regfile;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_oe, busy, wr_stb;
  logic [3:0] wr_addr, loc_addr;
  logic [7:0] wr_data, loc_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] wa[$];
  logic [7:0] wd[$];
  int   viol = 0;
  logic oe_seen = 1'b0, busy_seen = 1'b0;
  logic scl_q = 1'b1, oe_q = 1'b0;

  always #5 clk = ~clk;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  i2c_target_regfile #(.I2C_ADDR(7'h50), .PTR_W(4), .FILTER(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .loc_addr (loc_addr),
    .loc_rdata(loc_rdata)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (sda_oe) oe_seen <= 1'b1;
    if (busy)   busy_seen <= 1'b1;
    if (scl_i && scl_q && sda_oe !== oe_q) viol <= viol + 1;
    scl_q <= scl_i;
    oe_q  <= sda_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    sda_m = b; wq(Q);
    scl_m = 1'b1;
    if (glitch) begin
      wq(Q / 2);
      scl_m = 1'b0; wq(1);
      scl_m = 1'b1; wq(Q - Q / 2 - 1);
    end else begin
      wq(Q);
    end
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q / 2);
    b = sda_i; wq(Q - Q / 2);
    scl_m = 1'b0; wq(Q);
  endtask

  // nack = 1 when the target did not pull SDA low in the ACK slot
  task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic nack);
    for (int i = 7; i >= 0; i--) write_bit(b[i], (7 - i) == glitch_bit);
    read_bit(nack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) read_bit(b[i]);
    write_bit(nack, 1'b0);
  endtask

  task automatic wb(input string tag, input logic [7:0] b, input logic exp_nack);
    logic nk;
    write_byte(b, -1, nk);
    chk(tag, nk, exp_nack);
  endtask

  task automatic loc_rd(input string tag, input logic [3:0] idx, input logic [7:0] exp);
    @(negedge clk) loc_addr = idx;
    @(negedge clk) chk(tag, loc_rdata, exp);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [3:0] a, input logic [7:0] d);
    if (idx < wa.size()) begin
      chk({tag, "_addr"}, wa[idx], a);
      chk({tag, "_data"}, wd[idx], d);
    end else begin
      chk({tag, "_count"}, wa.size(), idx + 1);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       nk;
    int         n0;
    loc_addr = '0;
    wq(4);
    @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_loc_rdata", loc_rdata, 0);
    reset = 1'b0;
    wq(Q);

    // preload mem[1] so the pointer value after the burst is observable
    i2c_start(); wb("pre_addr", 8'hA0, 0); wb("pre_ptr", 8'h01, 0); wb("pre_d", 8'h5C, 0); i2c_stop();
    chk_wr("pre_wr", 0, 4'd1, 8'h5C);

    // write burst wrapping 14,15,0
    i2c_start();
    wb("bw_addr", 8'hA0, 0);
    wb("bw_ptr", 8'h0E, 0);
    chk("bw_busy", busy, 1);
    wb("bw_d0", 8'h11, 0); wb("bw_d1", 8'h22, 0); wb("bw_d2", 8'h33, 0);
    i2c_stop();
    chk("bw_busy_stop", busy, 0);
    chk_wr("bw_wr0", 1, 4'd14, 8'h11);
    chk_wr("bw_wr1", 2, 4'd15, 8'h22);
    chk_wr("bw_wr2", 3, 4'd0,  8'h33);
    loc_rd("bw_loc0", 4'd0, 8'h33);

    // current-address read: pointer must be 1
    i2c_start(); wb("cr_addr", 8'hA1, 0); read_byte(1'b1, rd); chk("cr_data", rd, 8'h5C); i2c_stop();

    // repeated-START read from 0x0F
    i2c_start(); wb("rr_addr", 8'hA0, 0); wb("rr_ptr", 8'h0F, 0);
    i2c_rstart(); wb("rr_addr_rd", 8'hA1, 0);
    read_byte(1'b0, rd); chk("rr_d0", rd, 8'h22);
    read_byte(1'b1, rd); chk("rr_d1", rd, 8'h33);
    wq(Q);
    chk("rr_released", sda_oe, 0);
    chk("rr_busy", busy, 1);
    i2c_stop();
    chk("rr_busy_stop", busy, 0);

    // address mismatch
    n0 = wa.size(); oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start(); wb("am_addr", 8'hA2, 1); wb("am_d", 8'h55, 1); i2c_stop();
    chk("am_oe_seen", oe_seen, 0);
    chk("am_busy_seen", busy_seen, 0);
    chk("am_wr_count", wa.size(), n0);
    loc_rd("am_loc0", 4'd0, 8'h33);
    loc_rd("am_loc5", 4'd5, 8'h00);

    // glitch on SCL during bit 3 of the data byte
    n0 = wa.size();
    i2c_start(); wb("gl_addr", 8'hA0, 0); wb("gl_ptr", 8'h05, 0);
    write_byte(8'h5A, 3, nk); chk("gl_ack", nk, 0);
    i2c_stop();
    chk_wr("gl_wr", n0, 4'd5, 8'h5A);
    chk("gl_wr_count", wa.size(), n0 + 1);
    loc_rd("gl_loc5", 4'd5, 8'h5A);

    // pointer truncation
    n0 = wa.size();
    i2c_start(); wb("pt_addr", 8'hA0, 0); wb("pt_ptr", 8'hF3, 0); wb("pt_d", 8'h77, 0); i2c_stop();
    chk_wr("pt_wr", n0, 4'd3, 8'h77);
    loc_rd("pt_loc3", 4'd3, 8'h77);

    // reset while the target drives bit 7 (=0) of mem[5]
    i2c_start(); wb("rm_addr", 8'hA0, 0); wb("rm_ptr", 8'h05, 0);
    i2c_rstart(); wb("rm_addr_rd", 8'hA1, 0);
    chk("rm_pre_oe", sda_oe, 1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) chk("rm_oe_released", sda_oe, 0);
    wq(3);
    @(negedge clk) reset = 1'b0;
    loc_rd("rm_loc5", 4'd5, 8'h00);
    loc_rd("rm_loc3", 4'd3, 8'h00);
    loc_rd("rm_loc0", 4'd0, 8'h00);
    chk("rm_busy", busy, 0);
    wq(2 * Q);
    n0 = wa.size();
    i2c_start(); wb("rw_addr", 8'hA0, 0); wb("rw_ptr", 8'h02, 0); wb("rw_d", 8'hC3, 0); i2c_stop();
    chk_wr("rw_wr", n0, 4'd2, 8'hC3);
    loc_rd("rw_loc2", 4'd2, 8'hC3);

    chk("sda_change_while_scl_high", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
